// File: rtl/asi_pkg.sv
// Shared types for the AXI write slave slice.
//   burst_t : AWBURST encodings (FIXED/INCR/WRAP/reserved)
//   RESP_*  : BRESP codes
//   state_t : write-channel FSM state
package asi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2,
    BURST_RSVD  = 2'd3
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/asi_addr_gen.sv
// Next-beat address generator (purely combinational).
//   cur_addr  : address of the beat being accepted
//   size      : log2 bytes per beat
//   len       : beats minus one (sets the WRAP window)
//   burst     : burst type
//   next_addr : address of the following beat
module asi_addr_gen
  import asi_pkg::*;
#(
  parameter int AXI_AW = 32,
  parameter int AXI_LW = 8
) (
  input  logic [AXI_AW-1:0] cur_addr,
  input  logic [2:0]        size,
  input  logic [AXI_LW-1:0] len,
  input  burst_t            burst,
  output logic [AXI_AW-1:0] next_addr
);

  logic [AXI_AW-1:0] step;
  logic [AXI_AW-1:0] win_mask;

  assign step     = AXI_AW'(1) << size;
  assign win_mask = ((AXI_AW'(len) + AXI_AW'(1)) << size) - AXI_AW'(1);

  always_comb begin
    next_addr = cur_addr;
    case (burst)
      // Aligning here makes an unaligned start address affect beat 0 only.
      BURST_INCR: next_addr = (cur_addr & ~(step - AXI_AW'(1))) + step;
      // Keep the window base bits, advance only the in-window offset.
      BURST_WRAP: next_addr = (cur_addr & ~win_mask) | ((cur_addr + step) & win_mask);
      default:    next_addr = cur_addr;
    endcase
  end

endmodule

// File: rtl/asi_w.sv
// AXI4 write-channel slave bridging one burst at a time to a simple user
// write port.
//   AW*      : burst request, accepted only in IDLE
//   W*       : write beats, accepted in DATA when the user side is ready
//              (or unconditionally once the burst is in error)
//   B*       : single response per burst, BID = captured AWID
//   usr_*    : zero-latency write strobe/address/data/strobes per beat
module asi_w
  import asi_pkg::*;
#(
  parameter int AXI_DW = 128,
  parameter int AXI_AW = 32,
  parameter int AXI_IW = 8,
  parameter int AXI_LW = 8
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [AXI_IW-1:0]     AWID,
  input  logic [AXI_AW-1:0]     AWADDR,
  input  logic [AXI_LW-1:0]     AWLEN,
  input  logic [2:0]            AWSIZE,
  input  logic [1:0]            AWBURST,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [AXI_DW-1:0]     WDATA,
  input  logic [AXI_DW/8-1:0]   WSTRB,
  input  logic                  WLAST,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [AXI_IW-1:0]     BID,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  output logic                  usr_we,
  output logic [AXI_AW-1:0]     usr_waddr,
  output logic [AXI_DW-1:0]     usr_wdata,
  output logic [AXI_DW/8-1:0]   usr_wstrb,
  input  logic                  usr_wready
);

  localparam int SZ_MAX = $clog2(AXI_DW / 8);

  state_t              state;
  logic                aw_ok;
  logic [AXI_IW-1:0]   id_q;
  logic [AXI_AW-1:0]   cur_addr;
  logic [AXI_AW-1:0]   next_addr;
  logic [AXI_LW-1:0]   len_q;
  logic [AXI_LW-1:0]   beat_cc;
  logic [2:0]          size_q;
  burst_t              burst_q;
  logic                err;
  logic                cap_err;
  logic                last_beat;
  logic                w_hs;

  asi_addr_gen #(
    .AXI_AW (AXI_AW),
    .AXI_LW (AXI_LW)
  ) u_addr_gen (
    .cur_addr  (cur_addr),
    .size      (size_q),
    .len       (len_q),
    .burst     (burst_q),
    .next_addr (next_addr)
  );

  always_comb begin
    cap_err = 1'b0;
    if (AWBURST == 2'd3)
      cap_err = 1'b1;
    if (AWSIZE > 3'(SZ_MAX))
      cap_err = 1'b1;
    if (AWBURST == 2'd2 &&
        !(AWLEN == AXI_LW'(1) || AWLEN == AXI_LW'(3) ||
          AWLEN == AXI_LW'(7) || AWLEN == AXI_LW'(15)))
      cap_err = 1'b1;
  end

  assign last_beat = (beat_cc == len_q);
  // aw_ok holds AWREADY low while in reset and until the first clock after it.
  assign AWREADY   = (state == ST_IDLE) && aw_ok;
  assign WREADY    = (state == ST_DATA) && (usr_wready || err);
  assign w_hs      = WVALID && WREADY;
  assign BVALID    = (state == ST_RESP);
  assign BID       = id_q;
  assign BRESP     = err ? RESP_SLVERR : RESP_OKAY;
  assign usr_we    = w_hs && !err;
  assign usr_waddr = cur_addr;
  assign usr_wdata = WDATA;
  assign usr_wstrb = WSTRB;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state    <= ST_IDLE;
      aw_ok    <= 1'b0;
      id_q     <= '0;
      cur_addr <= '0;
      len_q    <= '0;
      beat_cc  <= '0;
      size_q   <= '0;
      burst_q  <= BURST_FIXED;
      err      <= 1'b0;
    end else begin
      aw_ok <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (AWVALID && AWREADY) begin
            id_q     <= AWID;
            cur_addr <= AWADDR;
            len_q    <= AWLEN;
            size_q   <= AWSIZE;
            burst_q  <= burst_t'(AWBURST);
            beat_cc  <= '0;
            err      <= cap_err;
            state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_hs) begin
            cur_addr <= next_addr;
            if (WLAST != last_beat)
              err <= 1'b1;
            if (last_beat)
              state <= ST_RESP;
            else
              beat_cc <= beat_cc + AXI_LW'(1);
          end
        end
        ST_RESP: begin
          if (BREADY)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
